// File: rtl/pipeline_perf_monitor_if.sv
// Control, event and read-back signals between the performance monitor and its driver.
interface pipeline_perf_monitor_if #(
  parameter int CNT_WIDTH = 32,
  parameter int NUM_EVT   = 4,
  parameter int SEL_WIDTH = 4
);
  logic                 start;
  logic                 stop;
  logic                 clear;
  logic [CNT_WIDTH-1:0] cycle_limit;
  logic [NUM_EVT-1:0]   evt;
  logic [SEL_WIDTH-1:0] rd_sel;
  logic [CNT_WIDTH-1:0] rd_data;
  logic [NUM_EVT:0]     ovf;
  logic                 running;
  logic                 done;

  modport master (
    output start, stop, clear, cycle_limit, evt, rd_sel,
    input  rd_data, ovf, running, done
  );

  modport slave (
    input  start, stop, clear, cycle_limit, evt, rd_sel,
    output rd_data, ovf, running, done
  );
endinterface

// File: rtl/pipeline_perf_monitor.sv
// Run-window controller with saturating cycle/event counters and a registered read port.
// Counter 0 is the cycle counter; counter k (k >= 1) counts event strobe k-1.
module pipeline_perf_monitor #(
  parameter int CNT_WIDTH = 32,
  parameter int NUM_EVT   = 4,
  parameter int SEL_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  pipeline_perf_monitor_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                          state_reg, state_next;
  logic [CNT_WIDTH-1:0]            limit_reg;
  logic [CNT_WIDTH-1:0]            rd_data_reg, rd_mux;
  logic                            running_reg, done_reg;
  logic [NUM_EVT:0][CNT_WIDTH-1:0] cnt_vec;
  logic [NUM_EVT:0]                ovf_vec;
  logic [NUM_EVT:0]                inc_vec;
  logic [CNT_WIDTH-1:0]            cyc_after;
  logic                            limit_hit;
  logic                            zero_cnt;
  logic                            counting;

  assign inc_vec  = {bus.evt, 1'b1};
  assign zero_cnt = bus.clear | bus.start;
  assign counting = (state_reg == RUN) && !zero_cnt;

  // Limit compares against the value the cycle counter takes at this edge.
  assign cyc_after = (&cnt_vec[0]) ? cnt_vec[0] : cnt_vec[0] + CNT_WIDTH'(1);
  assign limit_hit = (limit_reg != '0) && (cyc_after == limit_reg);

  always_comb begin
    state_next = state_reg;
    if (bus.clear) begin
      state_next = IDLE;
    end else if (bus.start) begin
      state_next = RUN;
    end else if ((state_reg == RUN) && (bus.stop || limit_hit)) begin
      state_next = DONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
      limit_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      running_reg <= (state_next == RUN);
      done_reg    <= (state_next == DONE);
      if (bus.clear) begin
        limit_reg <= '0;
      end else if (bus.start) begin
        limit_reg <= bus.cycle_limit;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi <= NUM_EVT; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_reg;
      logic                 ovf_reg;

      // Saturating counter: holds at all-ones and raises a sticky overflow flag.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg <= '0;
          ovf_reg <= 1'b0;
        end else if (zero_cnt) begin
          cnt_reg <= '0;
          ovf_reg <= 1'b0;
        end else if (counting && inc_vec[gi]) begin
          if (&cnt_reg) begin
            ovf_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_WIDTH'(1);
          end
        end
      end

      assign cnt_vec[gi] = cnt_reg;
      assign ovf_vec[gi] = ovf_reg;
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k <= NUM_EVT; k++) begin
      if (bus.rd_sel == SEL_WIDTH'(k)) begin
        rd_mux = cnt_vec[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= rd_mux;
    end
  end

  assign bus.rd_data = rd_data_reg;
  assign bus.ovf     = ovf_vec;
  assign bus.running = running_reg;
  assign bus.done    = done_reg;

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Self-checking bench: read expectations queue up as reads are issued and are
// checked when the registered read data appears one edge later.
module tb_pipeline_perf_monitor;

  localparam int CW = 4;
  localparam int NE = 4;
  localparam int SW = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  pipeline_perf_monitor_if #(.CNT_WIDTH(CW), .NUM_EVT(NE), .SEL_WIDTH(SW)) bus ();

  pipeline_perf_monitor #(.CNT_WIDTH(CW), .NUM_EVT(NE), .SEL_WIDTH(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [SW-1:0] sel;
    int            exp_val;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  logic    rd_vld = 1'b0;
  int      n_chk  = 0;
  int      n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_val);
    n_chk++;
    if (got === exp_val) begin
      n_pass++;
      $display("ok   %s: %0d", tag, got);
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp_val);
    end
  endtask

  // One clock edge with the given pulses/strobes; outputs are settled on return.
  task automatic step(input logic s, input logic p, input logic c, input logic [NE-1:0] e);
    @(negedge clk);
    bus.start = s;
    bus.stop  = p;
    bus.clear = c;
    bus.evt   = e;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.clear = 1'b0;
    bus.evt   = '0;
  endtask

  task automatic rd(input logic [SW-1:0] sel, input int exp_val);
    rd_exp_t t;
    @(negedge clk);
    bus.rd_sel = sel;
    rd_vld     = 1'b1;
    t.sel      = sel;
    t.exp_val  = exp_val;
    sb_q.push_back(t);
  endtask

  task automatic rd_end();
    @(negedge clk);
    rd_vld = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rd_vld) begin
      rd_exp_t t;
      #1;
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        t = sb_q.pop_front();
        check($sformatf("rd_sel%0d", t.sel), 32'(bus.rd_data), 32'(t.exp_val));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          exp_tab[5] = '{10, 5, 3, 0, 2};
    int          n_run;
    logic [NE-1:0] e;

    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.clear       = 1'b0;
    bus.evt         = '0;
    bus.rd_sel      = '0;
    bus.cycle_limit = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_running", 32'(bus.running), 32'd0);
    check("rst_done",    32'(bus.done),    32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_ovf",     32'(bus.ovf),     32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Strobes in IDLE must not count.
    step(1'b0, 1'b0, 1'b0, 4'hF);
    check("idle_running", 32'(bus.running), 32'd0);
    rd(0, 0);
    rd(1, 0);
    rd_end();

    // Basic run, 10 counted cycles, stop on the 10th.
    step(1'b1, 1'b0, 1'b0, 4'h0);
    check("basic_running", 32'(bus.running), 32'd1);
    for (int i = 0; i < 10; i++) begin
      e[0] = (i % 2 == 0);
      e[1] = (i < 3);
      e[2] = 1'b0;
      e[3] = (i >= 8);
      step(1'b0, (i == 9), 1'b0, e);
    end
    check("basic_done",    32'(bus.done),    32'd1);
    check("basic_running_off", 32'(bus.running), 32'd0);
    check("basic_ovf",     32'(bus.ovf),     32'd0);
    for (int s = 0; s < 16; s++) begin
      rd(SW'(s), (s < 5) ? exp_tab[s] : 0);
    end
    rd_end();

    // Auto-stop after 7 cycles.
    bus.cycle_limit = CW'(7);
    step(1'b1, 1'b0, 1'b0, 4'h0);
    bus.cycle_limit = '0;
    n_run = bus.running ? 1 : 0;
    for (int i = 0; i < 20 && !bus.done; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'h0);
      if (bus.running) n_run++;
    end
    check("auto_run_cycles", 32'(n_run), 32'd7);
    check("auto_done",       32'(bus.done), 32'd1);
    rd(0, 7);
    rd_end();
    step(1'b0, 1'b1, 1'b0, 4'h0);
    check("auto_late_stop_done",    32'(bus.done),    32'd1);
    check("auto_late_stop_running", 32'(bus.running), 32'd0);
    rd(0, 7);
    rd_end();

    // Saturation: evt[1] held for 20 cycles, 21 counted cycles in total.
    step(1'b1, 1'b0, 1'b0, 4'h0);
    repeat (20) step(1'b0, 1'b0, 1'b0, 4'b0010);
    step(1'b0, 1'b1, 1'b0, 4'h0);
    check("sat_done", 32'(bus.done), 32'd1);
    check("sat_ovf",  32'(bus.ovf),  32'b00101);
    rd(0, 15);
    rd(2, 15);
    rd(1, 0);
    rd_end();
    step(1'b1, 1'b0, 1'b0, 4'h0);
    check("restart_ovf",     32'(bus.ovf),     32'd0);
    check("restart_running", 32'(bus.running), 32'd1);
    rd(0, 0);
    rd(2, 0);
    rd_end();

    // start+stop together while running: restart.
    repeat (3) step(1'b0, 1'b0, 1'b0, 4'b0001);
    step(1'b1, 1'b1, 1'b0, 4'h0);
    check("startstop_running", 32'(bus.running), 32'd1);
    check("startstop_done",    32'(bus.done),    32'd0);
    rd(0, 0);
    rd(1, 0);
    rd_end();

    // clear+start together: clear wins.
    repeat (2) step(1'b0, 1'b0, 1'b0, 4'b0001);
    step(1'b1, 1'b0, 1'b1, 4'h0);
    check("clrstart_running", 32'(bus.running), 32'd0);
    check("clrstart_done",    32'(bus.done),    32'd0);
    rd(0, 0);
    rd(1, 0);
    rd_end();
    step(1'b0, 1'b0, 1'b0, 4'hF);
    check("clr_idle_hold", 32'(bus.running), 32'd0);

    // Asynchronous reset between edges while running.
    step(1'b1, 1'b0, 1'b0, 4'h0);
    bus.rd_sel = '0;
    repeat (4) step(1'b0, 1'b0, 1'b0, 4'b0001);
    check("pre_rst_running", 32'(bus.running), 32'd1);
    check("pre_rst_rd_data", 32'(bus.rd_data), 32'd3);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_running", 32'(bus.running), 32'd0);
    check("async_rst_done",    32'(bus.done),    32'd0);
    check("async_rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("async_rst_ovf",     32'(bus.ovf),     32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0, 4'hF);
    check("post_rst_running", 32'(bus.running), 32'd0);
    check("post_rst_done",    32'(bus.done),    32'd0);
    rd(0, 0);
    rd(1, 0);
    rd_end();

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipeline_perf_monitor.md
Name: pipeline_perf_monitor

Overview:
- Synthesizable run-control and event-counting harness beside the five-stage PipeLine core.
- Counts the cycles of a run window and NUM_EVT per-cycle event strobes (retire, stall, flush, memory access, ...) from the core.
- Stops itself after a programmable cycle limit or on request.
- Exposes all counters through a registered read port for the bench or a debug bus.

Parameters:
- CNT_WIDTH, 32: width of the cycle counter and of every event counter.
- NUM_EVT, 4: number of event input channels, 1..15.
- SEL_WIDTH, 4: width of the read select; must satisfy 2^SEL_WIDTH >= NUM_EVT+1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- start  in  1  pulse: begin a run window (clears counters).
- stop  in  1  pulse: end the current run window.
- clear  in  1  pulse: return to IDLE and zero all counters and flags.
- cycle_limit  in  CNT_WIDTH  auto-stop after this many RUN cycles; 0 = no limit; sampled on start.
- evt  in  NUM_EVT  per-cycle event strobes from the pipeline.
- rd_sel  in  SEL_WIDTH  0 = cycle counter, k = event counter k-1; other values read 0.
- rd_data  out  CNT_WIDTH  registered read data.
- ovf  out  NUM_EVT+1  sticky saturation flags; bit 0 = cycle counter, bit k = event k-1.
- running  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Reset (reset low, asynchronous):
  - FSM goes to IDLE.
  - All counters, ovf, rd_data, running and done are 0.
  - Latched limit is 0.
- States: IDLE, RUN, DONE. Encoding is free; running and done are registered decodes of the state.
- Transitions:
  - IDLE -> RUN on start. Same edge: all counters and ovf are zeroed; cycle_limit is latched.
  - RUN -> DONE on stop.
  - RUN -> DONE when the latched limit is nonzero and the cycle counter, after incrementing this cycle, equals the latched limit.
  - DONE -> RUN on start, re-zeroing counters and re-latching the limit.
  - Any state -> IDLE on clear; counters and ovf are zeroed.
- Priority of simultaneous pulses: clear > start > stop.
  - start and stop together in RUN: the run restarts.
- Counting happens only in RUN, including the cycle on which stop or the limit forces DONE.
  - The cycle counter increments once per RUN cycle.
  - Event counter k increments when evt[k] is high in a RUN cycle.
  - The start cycle itself is not counted. The first counted cycle is the one after the edge that entered RUN.
  - Hence start at edge N, stop sampled at edge N+M: cycle counter = M.
- Auto-stop with limit L: the cycle counter is exactly L in DONE.
- Saturation:
  - A counter at all-ones holds its value.
  - Its ovf bit sets on the cycle an increment is attempted at all-ones.
  - ovf bits are sticky until start, clear or reset.
  - There is no wrap-around.
- Counters and ovf hold their values in DONE and IDLE; they are cleared only by start, clear or reset.
- Read port:
  - rd_data is registered, so rd_data at edge N+1 reflects rd_sel and the counter values as sampled at edge N.
  - Reads are legal in any state.
  - Out-of-range rd_sel returns 0.
- Event strobes are sampled synchronously, so callers must supply clk-domain signals.
- An evt bit held high across many RUN cycles counts once per cycle.
- Reset asserted mid-run: the block returns to IDLE immediately, with all counts lost; no DONE is produced.

Test Plan:
- Basic run:
  - Stimulus: reset low for 3 cycles, then high; limit 0; start; evt[0] high on 5 of 10 cycles; stop after 10 counted cycles.
  - Required: done=1; rd_sel 0 gives 10; rd_sel 1 gives 5; ovf=0.
- Auto-stop:
  - Stimulus: cycle_limit=7; start; stop never pulsed.
  - Required: running high for exactly 7 cycles; done then rises; cycle counter 7; a later stop has no effect.
- Saturation:
  - Stimulus: CNT_WIDTH=4; start; evt[1] held high for 20 cycles.
  - Required: event counter 1 reads 15; ovf[2]=1; cycle counter 15 with ovf[0]=1.
  - Then: start again; required: counters 0 and ovf 0.
- Simultaneous pulses:
  - Stimulus: in RUN, start and stop together.
  - Required: state RUN; counters zeroed.
  - Stimulus: clear with start.
  - Required: IDLE; counters 0.
- Read port:
  - Stimulus: in DONE with counts 10/5/3/0/2, sweep rd_sel 0..15.
  - Required: matching values one cycle later; 0 for rd_sel 5..15.
- Async reset mid-run:
  - Stimulus: reset driven low between clock edges during RUN.
  - Required: running, done, rd_data and ovf go to 0 without waiting for a clock edge; the block remains in IDLE after reset releases until start.
